// File: rtl/timeout_watchdog_mc.sv
// Multi-channel timeout watchdog.
// A shared prescaler produces a tick; each channel counts ticks up to its own
// latched limit and reports expiry with a one-cycle pulse plus a sticky flag.
// Channels are independent apart from the shared tick.

// ---------------------------------------------------------------------------
// Shared prescaler: free-running counter that ticks and wraps when it reaches
// presc_div, so the tick period is presc_div + 1 clk cycles.
// ---------------------------------------------------------------------------
module timeout_watchdog_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc_div,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    // Using >= rather than == means a divider lowered below the current count
    // wraps immediately instead of running all the way round.
    assign tick = (presc_cnt >= presc_div);

    // Advance the prescaler, wrapping on every tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every register
        // samples the pre-edge values of its neighbours, whatever the order.
        if (rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

endmodule

// ---------------------------------------------------------------------------
// One timeout channel: IDLE -> COUNT -> EXPIRED state machine with a shadow
// limit, registered expiry pulse and sticky flag.
// ---------------------------------------------------------------------------
module timeout_watchdog_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             kick,
    input  logic             autorel,
    input  logic [CNT_W-1:0] limit,
    input  logic             ack,
    output logic             pulse,
    output logic             flag,
    output logic             flag_nxt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] last_cnt;
    logic             shadow_zero;
    logic             cnt_sat;
    logic             expire;

    // A shadow limit of zero disables expiry; the counter then saturates.
    assign shadow_zero = (shadow == '0);
    assign cnt_sat     = (cnt == '1);
    assign last_cnt    = shadow - CNT_W'(1);

    // Expiry decode and next sticky-flag value; a kick or a disable in the
    // same cycle suppresses expiry, and a set beats a coincident ack.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        expire   = 1'b0;
        flag_nxt = flag & ~ack;
        if ((state == COUNT) && en && !kick && tick && !shadow_zero &&
            (cnt == last_cnt)) begin
            expire = 1'b1;
        end
        if (expire) begin
            flag_nxt = 1'b1;
        end
    end

    // Channel state machine with registered pulse and flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            pulse  <= 1'b0;
            flag   <= 1'b0;
        end else begin
            pulse <= expire;
            flag  <= flag_nxt;

            if (!en) begin
                // Disable wins from any state; the flag is left alone.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state  <= COUNT;
                        cnt    <= '0;
                        shadow <= limit;
                    end

                    COUNT: begin
                        if (kick) begin
                            // Restart beats a same-cycle tick.
                            cnt    <= '0;
                            shadow <= limit;
                        end else if (tick) begin
                            if (expire) begin
                                state <= EXPIRED;
                                cnt   <= '0;
                            end else if (shadow_zero) begin
                                if (!cnt_sat) begin
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    EXPIRED: begin
                        // One-shot parks here until disabled, ignoring kicks;
                        // auto-reload re-arms after a single cycle.
                        cnt <= '0;
                        if (autorel) begin
                            state  <= COUNT;
                            shadow <= limit;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Top level: prescaler, channel array and the registered any_timeout summary.
// ---------------------------------------------------------------------------
module timeout_watchdog_mc #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESC_W-1:0]    presc_div,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       ch_kick,
    input  logic [N_CH-1:0]       ch_autorel,
    input  logic [N_CH*CNT_W-1:0] time_limit,
    input  logic [N_CH-1:0]       ch_ack,
    output logic [N_CH-1:0]       timeout_pulse,
    output logic [N_CH-1:0]       timeout_flag,
    output logic                  any_timeout
);

    logic            tick;
    logic [N_CH-1:0] flag_nxt;

    timeout_watchdog_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .presc_div (presc_div),
        .tick      (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timeout_watchdog_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .en       (ch_en[i]),
            .kick     (ch_kick[i]),
            .autorel  (ch_autorel[i]),
            .limit    (time_limit[i*CNT_W +: CNT_W]),
            .ack      (ch_ack[i]),
            .pulse    (timeout_pulse[i]),
            .flag     (timeout_flag[i]),
            .flag_nxt (flag_nxt[i])
        );
    end

    // Summary flag is built from next-state flags so it lines up with
    // timeout_flag cycle for cycle while still coming straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_timeout <= 1'b0;
        end else begin
            any_timeout <= |flag_nxt;
        end
    end

endmodule
